// File: rtl/hanning_frame_sequencer.sv
// rtl/hanning_frame_sequencer.sv - frame sequencer for the Hanning windowing datapath
//
// Admits exactly SAMPLE_COUNT audio samples per frame once the FFT is ready,
// drives the window coefficient ROM address and pipeline advance, and carries
// first/last/in-frame tags alongside the datapath so frame markers line up
// with the windowed output samples.
//
// Ports:
//   clk_in                  system clock
//   rst_n_in                asynchronous active-low reset
//   enable_in               run request, sampled in IDLE and at end of frame
//   audio_sample_valid_in   one-cycle strobe per audio sample
//   fft_ready_in            FFT can accept a new frame
//   coeff_addr_out          coefficient ROM address for the current sample
//   window_en_out           advance the windowing pipeline (combinational)
//   frame_sample_valid_out  windowed output this cycle belongs to the frame
//   frame_first_out         first sample of frame
//   frame_last_out          last sample of frame
//   frame_done_out          one-cycle pulse, frame fully delivered
//   dropped_count_out       saturating count of discarded samples
//   state_out               IDLE=0, WAIT_READY=1, FILL=2, FLUSH=3
module hanning_frame_sequencer #(
  parameter int SAMPLE_COUNT = 4096,
  parameter int ADDR_WIDTH   = 12,
  parameter int PIPE_LATENCY = 3,
  parameter int DROP_WIDTH   = 16
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  enable_in,
  input  logic                  audio_sample_valid_in,
  input  logic                  fft_ready_in,
  output logic [ADDR_WIDTH-1:0] coeff_addr_out,
  output logic                  window_en_out,
  output logic                  frame_sample_valid_out,
  output logic                  frame_first_out,
  output logic                  frame_last_out,
  output logic                  frame_done_out,
  output logic [DROP_WIDTH-1:0] dropped_count_out,
  output logic [1:0]            state_out
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_READY = 2'd1,
    FILL       = 2'd2,
    FLUSH      = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SAMPLE_COUNT - 1);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic                  drop_inc;

  // Tag layout: {in_frame, first, last}
  logic [2:0] tag_pipe [PIPE_LATENCY];
  logic [2:0] push_tag;
  logic [2:0] exit_tag;

  assign exit_tag      = tag_pipe[PIPE_LATENCY-1];
  assign window_en_out = audio_sample_valid_in && (state == FILL || state == FLUSH);
  assign state_out     = state;

  always_comb begin
    state_nxt = state;
    addr_nxt  = coeff_addr_out;
    push_tag  = 3'b000;
    drop_inc  = 1'b0;
    case (state)
      IDLE: begin
        if (enable_in) state_nxt = WAIT_READY;
      end
      WAIT_READY: begin
        // A sample arriving with fft_ready_in is still outside the frame.
        if (audio_sample_valid_in) drop_inc = 1'b1;
        if (fft_ready_in) begin
          state_nxt = FILL;
          addr_nxt  = '0;
        end
      end
      FILL: begin
        if (audio_sample_valid_in) begin
          push_tag = {1'b1, coeff_addr_out == '0, coeff_addr_out == LAST_ADDR};
          addr_nxt = coeff_addr_out + 1'b1;
          if (coeff_addr_out == LAST_ADDR) state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        addr_nxt = '0;
        if (audio_sample_valid_in) begin
          drop_inc = 1'b1;
          // Leave as the frame's last tag drops out of the pipe; the registered
          // last/done outputs appear in the same cycle as the new state.
          if (exit_tag[0]) state_nxt = enable_in ? WAIT_READY : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state                  <= IDLE;
      coeff_addr_out         <= '0;
      frame_sample_valid_out <= 1'b0;
      frame_first_out        <= 1'b0;
      frame_last_out         <= 1'b0;
      frame_done_out         <= 1'b0;
      dropped_count_out      <= '0;
      for (int i = 0; i < PIPE_LATENCY; i++) tag_pipe[i] <= 3'b000;
    end else begin
      state          <= state_nxt;
      coeff_addr_out <= addr_nxt;
      if (window_en_out) begin
        tag_pipe[0] <= push_tag;
        for (int i = 1; i < PIPE_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
        frame_sample_valid_out <= exit_tag[2];
        frame_first_out        <= exit_tag[1];
        frame_last_out         <= exit_tag[0];
        frame_done_out         <= exit_tag[0];
      end else begin
        frame_sample_valid_out <= 1'b0;
        frame_first_out        <= 1'b0;
        frame_last_out         <= 1'b0;
        frame_done_out         <= 1'b0;
      end
      if (drop_inc && dropped_count_out != '1)
        dropped_count_out <= dropped_count_out + 1'b1;
    end
  end

endmodule

// File: tb/tb_hanning_frame_sequencer.sv
// tb/tb_hanning_frame_sequencer.sv - scoreboard bench for hanning_frame_sequencer
module tb_hanning_frame_sequencer;

  localparam int SC = 8;
  localparam int AW = 3;
  localparam int PL = 3;
  localparam int DW = 3;

  logic          clk_in = 1'b0;
  logic          rst_n_in = 1'b0;
  logic          enable_in = 1'b0;
  logic          audio_sample_valid_in = 1'b0;
  logic          fft_ready_in = 1'b0;
  logic [AW-1:0] coeff_addr_out;
  logic          window_en_out;
  logic          frame_sample_valid_out;
  logic          frame_first_out;
  logic          frame_last_out;
  logic          frame_done_out;
  logic [DW-1:0] dropped_count_out;
  logic [1:0]    state_out;

  hanning_frame_sequencer #(
    .SAMPLE_COUNT(SC), .ADDR_WIDTH(AW), .PIPE_LATENCY(PL), .DROP_WIDTH(DW)
  ) dut (
    .clk_in(clk_in),
    .rst_n_in(rst_n_in),
    .enable_in(enable_in),
    .audio_sample_valid_in(audio_sample_valid_in),
    .fft_ready_in(fft_ready_in),
    .coeff_addr_out(coeff_addr_out),
    .window_en_out(window_en_out),
    .frame_sample_valid_out(frame_sample_valid_out),
    .frame_first_out(frame_first_out),
    .frame_last_out(frame_last_out),
    .frame_done_out(frame_done_out),
    .dropped_count_out(dropped_count_out),
    .state_out(state_out)
  );

  always #5 clk_in = ~clk_in;

  int passed = 0;
  int total  = 0;
  int cycles = 0;

  logic [AW-1:0] addr_q [$];
  logic [1:0]    tag_q  [$];   // {first, last}

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual === expected) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
  endtask

  task automatic flag(input string name);
    total++;
    $display("FAIL %s: got event, expected none at %0t", name, $time);
  endtask

  // Monitor: pops expectations whenever the DUT presents an advance or a tagged output.
  always @(negedge clk_in) begin
    logic [1:0] t;
    if (rst_n_in) begin
      if (window_en_out) begin
        if (addr_q.size() == 0) flag("unexpected_window_en");
        else check("coeff_addr", 32'(coeff_addr_out), 32'(addr_q.pop_front()));
      end
      if (frame_sample_valid_out) begin
        if (tag_q.size() == 0) flag("unexpected_frame_valid");
        else begin
          t = tag_q.pop_front();
          check("frame_first", 32'(frame_first_out), 32'(t[1]));
          check("frame_last", 32'(frame_last_out), 32'(t[0]));
          check("frame_done", 32'(frame_done_out), 32'(t[0]));
        end
      end else if (frame_first_out || frame_last_out || frame_done_out) begin
        flag("stray_frame_tag");
      end
    end
  end

  always @(posedge clk_in) begin
    cycles++;
    if (cycles > 5000) begin
      $display("FAIL watchdog: got %0d cycles expected under 5000", cycles);
      $display("%0d/%0d checks passed", passed, total + 1);
      $fatal(1);
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst_n_in = 1'b0;
    addr_q.delete();
    tag_q.delete();
    wait_cycles(2);
    rst_n_in = 1'b1;
  endtask

  // One valid strobe, then one idle cycle; returns #1 after the consuming edge.
  task automatic send_valid();
    @(posedge clk_in); #1;
    audio_sample_valid_in = 1'b1;
    @(posedge clk_in); #1;
    audio_sample_valid_in = 1'b0;
  endtask

  task automatic fill_samples(input int n, input int drop_en_after);
    for (int i = 0; i < n; i++) begin
      addr_q.push_back(AW'(i));
      tag_q.push_back({i == 0, i == SC - 1});
      send_valid();
      if (i + 1 == drop_en_after) enable_in = 1'b0;
    end
  endtask

  task automatic flush_samples();
    for (int i = 0; i < PL; i++) begin
      addr_q.push_back('0);
      send_valid();
    end
  endtask

  task automatic check_drained(input string name);
    wait_cycles(2);
    check({name, "_tags_left"}, 32'(tag_q.size()), 0);
    check({name, "_addrs_left"}, 32'(addr_q.size()), 0);
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_state", 32'(state_out), 0);
    check("rst_addr", 32'(coeff_addr_out), 0);
    check("rst_dropped", 32'(dropped_count_out), 0);
    check("rst_frame_valid", 32'(frame_sample_valid_out), 0);
    check("rst_done", 32'(frame_done_out), 0);

    // Full frame with flush
    enable_in = 1'b1; fft_ready_in = 1'b1;
    wait_cycles(3);
    check("t1_state_fill", 32'(state_out), 2);
    fill_samples(SC, 0);
    check("t1_state_flush", 32'(state_out), 3);
    flush_samples();
    check("t1_state_after", 32'(state_out), 1);
    fft_ready_in = 1'b0;
    check("t1_dropped", 32'(dropped_count_out), 3);
    check_drained("t1");
    enable_in = 1'b0;

    // Waiting for FFT: samples dropped, no advance
    do_reset();
    enable_in = 1'b1; fft_ready_in = 1'b0;
    wait_cycles(2);
    for (int i = 0; i < 5; i++) send_valid();
    check("t2_dropped", 32'(dropped_count_out), 5);
    check("t2_state", 32'(state_out), 1);

    // Ready coincident with a sample, then enable dropped after 4th sample
    do_reset();
    enable_in = 1'b1; fft_ready_in = 1'b0;
    wait_cycles(2);
    @(posedge clk_in); #1;
    fft_ready_in = 1'b1; audio_sample_valid_in = 1'b1;
    @(posedge clk_in); #1;
    fft_ready_in = 1'b0; audio_sample_valid_in = 1'b0;
    check("t3_dropped_coincident", 32'(dropped_count_out), 1);
    check("t3_state_fill", 32'(state_out), 2);
    fill_samples(SC, 4);
    flush_samples();
    check("t4_state_idle", 32'(state_out), 0);
    check("t4_dropped", 32'(dropped_count_out), 4);
    check_drained("t4");

    // Asynchronous reset mid-frame, then fresh frame
    do_reset();
    enable_in = 1'b1; fft_ready_in = 1'b1;
    wait_cycles(3);
    fill_samples(5, 0);
    check("t5_addr_before", 32'(coeff_addr_out), 5);
    check("t5_frame_valid_before", 32'(frame_sample_valid_out), 1);
    #2;
    rst_n_in = 1'b0;
    addr_q.delete();
    tag_q.delete();
    #1;
    check("t5_async_state", 32'(state_out), 0);
    check("t5_async_addr", 32'(coeff_addr_out), 0);
    check("t5_async_frame_valid", 32'(frame_sample_valid_out), 0);
    check("t5_async_done", 32'(frame_done_out), 0);
    wait_cycles(2);
    rst_n_in = 1'b1;
    wait_cycles(3);
    check("t5_restart_state", 32'(state_out), 2);
    fill_samples(SC, 0);
    flush_samples();
    fft_ready_in = 1'b0;
    check("t5_dropped", 32'(dropped_count_out), 3);
    check_drained("t5");

    // Saturation of the 3-bit drop counter
    do_reset();
    enable_in = 1'b1; fft_ready_in = 1'b0;
    wait_cycles(2);
    for (int i = 0; i < 10; i++) send_valid();
    check("t6_saturate", 32'(dropped_count_out), 7);
    check("t6_state", 32'(state_out), 1);

    wait_cycles(2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
